// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first WIDTH-bit adder sequencing one shared 1-bit full-adder cell
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic c_reg;
  logic [CNT_W-1:0] cnt;
  logic accept, cnt_last;
  assign accept = in_valid & in_ready;
  assign cnt_last = cnt == CNT_W'(WIDTH - 1);
  assign out_sum = sum_sh;
  assign out_cout = c_reg;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: an accept always starts RUN, including back-to-back from DONE
  always_comb begin
    state_nx = accept ? RUN :
               state == RUN ? (cnt_last ? DONE : RUN) :
               (state == DONE && out_ready) ? IDLE : state;
  end
  // handshake, status and full-adder drive; the cell sees zeros outside RUN
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
    busy = state == RUN;
    fa_a = state == RUN ? a_sh[0] : 1'b0;
    fa_b = state == RUN ? b_sh[0] : 1'b0;
    fa_c = state == RUN ? c_reg : 1'b0;
  end
  // operand capture, then one bit per RUN cycle through the shared cell
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      c_reg <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      a_sh <= in_a;
      b_sh <= in_b;
      sum_sh <= '0;
      c_reg <= in_cin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      c_reg <= fa_carry;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl with a behavioural full-adder cell
module tb_serial_adder_ctrl;
  localparam int W = 8;
  typedef struct {
    logic [W:0] ex;
    int acc;
  } item_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cout, busy, fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic [W-1:0] out_sum;
  item_t q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, busy_cnt = 0, prev_acc = 0;
  bit hold = 0, b2b = 0, have_prev = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy), .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry)
  );

  assign fa_sum = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] ex);
    n_chk++;
    if (got === ex) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, ex, cyc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      busy_cnt = 0;
      hold = 0;
    end else begin
      if (!busy) check("fa_idle", {29'd0, fa_a, fa_b, fa_c}, 0);
      if (busy) busy_cnt++;
      if (out_valid && !hold) begin
        check("busy_len", busy_cnt, W);
        busy_cnt = 0;
        if (q.size() == 0) check("unexpected_out", 1, 0);
        else check("latency", cyc - q[0].acc, W);
      end
      hold = out_valid && !out_ready;
      if (out_valid && out_ready && q.size() > 0) begin
        check("result", {23'd0, out_cout, out_sum}, {23'd0, q[0].ex});
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (b2b && have_prev) check("b2b_gap", cyc + 1 - prev_acc, W + 1);
        prev_acc = cyc + 1;
        have_prev = 1;
        q.push_back('{ex: {1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin), acc: cyc + 1});
      end
    end
  end

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    in_a = a;
    in_b = b;
    in_cin = c;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_op(8'h12, 8'h34, 1'b0);
    in_valid = 1'b0;
    drain();
    push_op(8'hFF, 8'h01, 1'b0);
    in_valid = 1'b0;
    drain();
    push_op(8'hA5, 8'h5A, 1'b1);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    push_op(8'h3C, 8'h0F, 1'b0);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) check("bp_timeout", 0, 1);
    repeat (5) begin
      check("bp_sum", out_sum, 8'h4B);
      check("bp_cout", out_cout, 0);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    check("bp_queue", q.size(), 0);
    @(posedge clk);
    #1;
    b2b = 1;
    have_prev = 0;
    push_op(8'h01, 8'h01, 1'b0);
    push_op(8'h80, 8'h80, 1'b0);
    push_op(8'h7F, 8'h01, 1'b0);
    in_valid = 1'b0;
    drain();
    b2b = 0;
    push_op(8'hFF, 8'hFF, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_cout", out_cout, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_op(8'h05, 8'h03, 1'b0);
    in_valid = 1'b0;
    drain();
    repeat (1000) begin
      push_op(W'($urandom), W'($urandom), 1'($urandom));
      for (int i = 0; i < W - 1; i++) begin
        in_valid = 1'($urandom);
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_cin = 1'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      drain();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
